cache_lru_engine: RTL and testbench
===================================

# cache_lru_engine

Parametrised set-associative cache model engine with a valid/ready request port and a one-cycle response pulse. It keeps valid, dirty, tag and replacement state per set and way. Replacement policy is selectable: true LRU or 1-bit NRU. It accumulates hit, miss, eviction and writeback statistics, and sits between the trace-driver front end and the statistics reporter.

## Interface
- NUM_SETS, 32, number of sets; power of two, ≥2
- NUM_WAYS, 8, associativity; 1..16
- LINE_SIZE, 64, line size in bytes; power of two, 32..128
- ADDR_W, 32, address width
- REPL_POLICY, 0, 0 = true LRU (age counters), 1 = 1-bit NRU
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept; high only in IDLE
- req_op  in  2  0 read, 1 write, 2 invalidate, 3 no-op
- req_addr  in  ADDR_W  request address
- stats_clear  in  1  synchronous clear of all counters
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  line was present and valid
- resp_way  out  WAY_W  way hit, filled or invalidated; WAY_W = max(1, clog2(NUM_WAYS))
- resp_evict  out  1  valid victim was replaced
- resp_writeback  out  1  evicted victim was dirty
- cnt_access, cnt_reads, cnt_writes, cnt_invalidates, cnt_hits, cnt_misses, cnt_evictions, cnt_writebacks  out  32 each  statistics

## Operation
- Address split: offset = clog2(LINE_SIZE) LSBs, then index = clog2(NUM_SETS) bits, tag = remaining MSBs.
- FSM states: IDLE → LOOKUP → UPDATE → IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready, op and address are registered.
  - LOOKUP: tag compare across all ways; hit way and victim are registered.
  - UPDATE: arrays, replacement state and counters are written; resp_* are registered.
- Victim selection: lowest-index invalid way; if all ways are valid, apply the policy.
  - True LRU: per-way age, clog2(NUM_WAYS) bits; reset age[w]=w. Touching way w increments every age < age[w], then sets age[w]=0. Victim is the way with age NUM_WAYS-1.
  - NRU: one bit per way. Touch sets the bit; if all bits would then be 1, clear every bit except the touched way. Victim is the lowest-index way with bit 0.
  - NUM_WAYS=1: victim is always way 0.
- Read hit: touch the way. Read miss: fill victim, valid=1, dirty=0, touch.
- Write hit: dirty=1, touch. Write miss (write-allocate): fill victim, dirty=1, touch.
- Eviction: victim was valid → resp_evict=1 and cnt_evictions++. Victim was also dirty → resp_writeback=1 and cnt_writebacks++.
- Invalidate:
  - On hit: valid=0, dirty=0, no writeback, replacement state unchanged.
  - resp_hit reports presence.
  - Counts cnt_invalidates only, not cnt_access.
- No-op (op 3): accepted; resp_valid pulses with all flags 0; no state or counter change.
- Read/write: cnt_access++, cnt_reads or cnt_writes++, cnt_hits or cnt_misses++.
- Counters wrap modulo 2^32.

## Timing
- Request accepted at edge E0 → LOOKUP after E0 → UPDATE after E1 → resp_valid high for exactly the cycle after E2, with req_ready=1 in that same cycle.
- Latency is 3 cycles; throughput is one request per 3 cycles.
- Back-to-back: a request may be accepted in the same cycle resp_valid is high.
- req_ready=0 in LOOKUP and UPDATE. req_valid in those states is ignored; the requester holds it.
- Reset values:
  - all valid, dirty and tag bits 0; true-LRU ages per above; NRU bits 0
  - counters 0; resp_* 0; req_ready 1; state IDLE
- rst mid-operation: request is abandoned, no resp_valid, arrays reset.
- stats_clear coinciding with UPDATE: clear wins; that request's counter increments are lost, but array updates and the response still occur.
- rst overrides stats_clear.
- resp_* hold their last values when resp_valid=0.

## Configuration
- CACHE_STATS_EN defined: all eight counters and stats_clear are implemented.
- CACHE_STATS_EN undefined:
  - counter outputs tied to 0; stats_clear ignored
  - resp_* and all cache behaviour unchanged

## Test plan
- Base configuration for all scenarios except where stated: NUM_SETS=32, NUM_WAYS=4, LINE_SIZE=64. Addresses 0x0, 0x800, 0x1000, 0x1800, 0x2000 all map to set 0.
- Reset, read 0x40, then read 0x40 again:
  - first read → miss, resp_way=0, evict=0
  - second read → hit, way 0
  - cnt_access=2, cnt_hits=1, cnt_misses=1
- True LRU: read 0x0, 0x800, 0x1000, 0x1800 (fills ways 0-3), read 0x0 (hit), read 0x2000 → way 1 replaced, evict=1, writeback=0.
- Write 0x0, read 0x800, 0x1000, 0x1800, read 0x2000 → way 0 replaced, writeback=1, cnt_writebacks=1, cnt_evictions=1.
- After filling set 0:
  - invalidate 0x800 → resp_hit=1, resp_way=1, cnt_invalidates=1, cnt_access unchanged
  - then read 0x2000 → fills way 1, evict=0
- REPL_POLICY=1: read 0x0, 0x800, 0x1000, 0x1800 (last touch leaves only bit3 set), read 0x2000 → victim way 0.
- Handshake and reset:
  - req_valid held high → req_ready low for 2 cycles after each accept; one response per 3 cycles
  - rst asserted in LOOKUP → no resp_valid; next read of the same address misses
  - stats_clear in UPDATE → all counters 0 on the following cycle

Source files
------------

// File: rtl/cache_lru_engine.sv
// Set-associative cache model engine: valid/dirty/tag/replacement state per set and way,
// true-LRU or NRU victim choice. Optional statistics counters behind `CACHE_STATS_EN`.
module cache_lru_engine #(
  parameter int NUM_SETS    = 32,
  parameter int NUM_WAYS    = 8,
  parameter int LINE_SIZE   = 64,
  parameter int ADDR_W      = 32,
  parameter int REPL_POLICY = 0,
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              stats_clear,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              resp_evict,
  output logic              resp_writeback,
  output logic [31:0]       cnt_access,
  output logic [31:0]       cnt_reads,
  output logic [31:0]       cnt_writes,
  output logic [31:0]       cnt_invalidates,
  output logic [31:0]       cnt_hits,
  output logic [31:0]       cnt_misses,
  output logic [31:0]       cnt_evictions,
  output logic [31:0]       cnt_writebacks
);
  localparam int OFF_W = $clog2(LINE_SIZE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
  typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_INV = 2'd2, OP_NOP = 2'd3} op_t;

  state_t state_q, state_d;

  // request registers
  op_t              op_r;
  logic [IDX_W-1:0] idx_r;
  logic [TAG_W-1:0] tag_r;

  // lookup results
  logic             hit_r, vic_valid_r, vic_dirty_r;
  logic [WAY_W-1:0] hit_way_r, vic_r;

  // cache state arrays
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]             valid_q, dirty_q, nru_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0]  age_q;

  logic [NUM_WAYS-1:0]             hit_vec, t_oh, nru_or, nru_nxt;
  logic [NUM_WAYS-1:0][WAY_W-1:0]  age_nxt;
  logic                            lk_hit, any_inv;
  logic [WAY_W-1:0]                lk_way, lk_vic, inv_vic, lru_vic, nru_vic, upd_way, age_t;

  logic unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_valid <= (state_q == UPDATE);
    end
  end

  // way that a read/write touches: the hit way, otherwise the fill victim
  assign upd_way = hit_r ? hit_way_r : vic_r;
  assign age_t   = age_q[idx_r][upd_way];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_q[idx_r][w] && (tag_q[idx_r][w] == tag_r);
    assign age_nxt[w] = (upd_way == WAY_W'(w))       ? WAY_W'(0) :
                        (age_q[idx_r][w] < age_t)    ? age_q[idx_r][w] + WAY_W'(1) :
                                                       age_q[idx_r][w];
  end

  always_comb begin
    t_oh          = '0;
    t_oh[upd_way] = 1'b1;
    nru_or        = nru_q[idx_r] | t_oh;
    nru_nxt       = (&nru_or) ? t_oh : nru_or;
  end

  // descending scans so the lowest matching index wins
  always_comb begin
    lk_hit  = |hit_vec;
    lk_way  = '0;
    lru_vic = '0;
    nru_vic = '0;
    inv_vic = '0;
    any_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) lk_way = WAY_W'(w);
      if (age_q[idx_r][w] == WAY_W'(NUM_WAYS - 1)) lru_vic = WAY_W'(w);
      if (!nru_q[idx_r][w]) nru_vic = WAY_W'(w);
      if (!valid_q[idx_r][w]) begin
        inv_vic = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    if (NUM_WAYS == 1)        lk_vic = '0;
    else if (any_inv)         lk_vic = inv_vic;
    else if (REPL_POLICY == 1) lk_vic = nru_vic;
    else                      lk_vic = lru_vic;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= OP_NOP;
      idx_r       <= '0;
      tag_r       <= '0;
      hit_r       <= 1'b0;
      hit_way_r   <= '0;
      vic_r       <= '0;
      vic_valid_r <= 1'b0;
      vic_dirty_r <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      op_r  <= op_t'(req_op);
      idx_r <= req_addr[OFF_W +: IDX_W];
      tag_r <= req_addr[ADDR_W-1 -: TAG_W];
    end else if (state_q == LOOKUP) begin
      hit_r       <= lk_hit;
      hit_way_r   <= lk_way;
      vic_r       <= lk_vic;
      vic_valid_r <= valid_q[idx_r][lk_vic];
      vic_dirty_r <= dirty_q[idx_r][lk_vic];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      tag_q          <= '0;
      nru_q          <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_evict     <= 1'b0;
      resp_writeback <= 1'b0;
    end else if (state_q == UPDATE) begin
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_evict     <= 1'b0;
      resp_writeback <= 1'b0;
      case (op_r)
        OP_RD, OP_WR: begin
          if (!hit_r) begin
            tag_q[idx_r][upd_way]   <= tag_r;
            valid_q[idx_r][upd_way] <= 1'b1;
            dirty_q[idx_r][upd_way] <= (op_r == OP_WR);
          end else if (op_r == OP_WR) begin
            dirty_q[idx_r][upd_way] <= 1'b1;
          end
          age_q[idx_r]   <= age_nxt;
          nru_q[idx_r]   <= nru_nxt;
          resp_hit       <= hit_r;
          resp_way       <= upd_way;
          resp_evict     <= !hit_r && vic_valid_r;
          resp_writeback <= !hit_r && vic_valid_r && vic_dirty_r;
        end
        OP_INV: begin
          // replacement state deliberately left untouched
          if (hit_r) begin
            valid_q[idx_r][hit_way_r] <= 1'b0;
            dirty_q[idx_r][hit_way_r] <= 1'b0;
          end
          resp_hit <= hit_r;
          resp_way <= hit_r ? hit_way_r : '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic rw_op;
  assign rw_op = (op_r == OP_RD) || (op_r == OP_WR);

  // clear beats a coinciding UPDATE; rst beats both
  always_ff @(posedge clk) begin
    if (rst || stats_clear) begin
      cnt_access      <= '0;
      cnt_reads       <= '0;
      cnt_writes      <= '0;
      cnt_invalidates <= '0;
      cnt_hits        <= '0;
      cnt_misses      <= '0;
      cnt_evictions   <= '0;
      cnt_writebacks  <= '0;
    end else if (state_q == UPDATE) begin
      if (rw_op) begin
        cnt_access <= cnt_access + 32'd1;
        if (op_r == OP_RD) cnt_reads  <= cnt_reads + 32'd1;
        else               cnt_writes <= cnt_writes + 32'd1;
        if (hit_r) cnt_hits   <= cnt_hits + 32'd1;
        else       cnt_misses <= cnt_misses + 32'd1;
        if (!hit_r && vic_valid_r) cnt_evictions <= cnt_evictions + 32'd1;
        if (!hit_r && vic_valid_r && vic_dirty_r) cnt_writebacks <= cnt_writebacks + 32'd1;
      end else if (op_r == OP_INV) begin
        cnt_invalidates <= cnt_invalidates + 32'd1;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr      = stats_clear;
  assign cnt_access      = '0;
  assign cnt_reads       = '0;
  assign cnt_writes      = '0;
  assign cnt_invalidates = '0;
  assign cnt_hits        = '0;
  assign cnt_misses      = '0;
  assign cnt_evictions   = '0;
  assign cnt_writebacks  = '0;
`endif

endmodule

// File: tb/tb_cache_lru_engine.sv
// Directed bench for cache_lru_engine: an LRU instance and an NRU instance share stimulus.
module tb_cache_lru_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd3;
  logic [31:0] req_addr = '0;
  logic        stats_clear = 1'b0;

  logic        req_ready, resp_valid, resp_hit, resp_evict, resp_writeback;
  logic [1:0]  resp_way;
  logic [31:0] cnt_access, cnt_reads, cnt_writes, cnt_invalidates;
  logic [31:0] cnt_hits, cnt_misses, cnt_evictions, cnt_writebacks;

  logic        n_ready, n_valid, n_hit, n_evict, n_wb;
  logic [1:0]  n_way;
  logic [31:0] n_c0, n_c1, n_c2, n_c3, n_c4, n_c5, n_c6, n_c7;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0, failures = 0, lat = 0;
  logic       r_hit, r_evict, r_wb, n_r_evict;
  logic [1:0] r_way, n_r_way;

  cache_lru_engine #(.NUM_SETS(32), .NUM_WAYS(4), .LINE_SIZE(64), .ADDR_W(32), .REPL_POLICY(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .stats_clear(stats_clear), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_evict(resp_evict), .resp_writeback(resp_writeback),
    .cnt_access(cnt_access), .cnt_reads(cnt_reads), .cnt_writes(cnt_writes),
    .cnt_invalidates(cnt_invalidates), .cnt_hits(cnt_hits), .cnt_misses(cnt_misses),
    .cnt_evictions(cnt_evictions), .cnt_writebacks(cnt_writebacks));

  cache_lru_engine #(.NUM_SETS(32), .NUM_WAYS(4), .LINE_SIZE(64), .ADDR_W(32), .REPL_POLICY(1)) dut_nru (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(n_ready), .req_op(req_op),
    .req_addr(req_addr), .stats_clear(stats_clear), .resp_valid(n_valid), .resp_hit(n_hit),
    .resp_way(n_way), .resp_evict(n_evict), .resp_writeback(n_wb),
    .cnt_access(n_c0), .cnt_reads(n_c1), .cnt_writes(n_c2), .cnt_invalidates(n_c3),
    .cnt_hits(n_c4), .cnt_misses(n_c5), .cnt_evictions(n_c6), .cnt_writebacks(n_c7));

  always #5 clk = ~clk;

  function automatic logic [31:0] ex(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req_valid = 1'b0; stats_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // issue one request from a negedge and return at the negedge where resp_valid is high
  task automatic do_req(input logic [1:0] op, input logic [31:0] addr);
    int n;
    req_op = op; req_addr = addr; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    checks++;
    if (!resp_valid) begin failures++; $display("FAIL req_timeout addr=%0h got resp_valid=%0b exp 1", addr, resp_valid); end
    r_hit = resp_hit; r_way = resp_way; r_evict = resp_evict; r_wb = resp_writeback;
    n_r_way = n_way; n_r_evict = n_evict;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if ({resp_hit, resp_way, resp_evict, resp_writeback} !== 5'b0) begin failures++;
      $display("FAIL reset_resp_flags got=%0b exp=0", {resp_hit, resp_way, resp_evict, resp_writeback}); end
    checks++; if ((cnt_access | cnt_misses | cnt_hits | cnt_evictions) !== 32'd0) begin failures++;
      $display("FAIL reset_counters got=%0h exp=0", cnt_access | cnt_misses | cnt_hits | cnt_evictions); end
  endtask

  task automatic test_read_hit();
    apply_reset();
    do_req(2'd0, 32'h40);
    checks++; if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
    checks++; if ({r_hit, r_way, r_evict} !== 4'b0_00_0) begin failures++;
      $display("FAIL first_read got hit/way/evict=%0b/%0d/%0b exp 0/0/0", r_hit, r_way, r_evict); end
    do_req(2'd0, 32'h40);
    checks++; if ({r_hit, r_way} !== 3'b1_00) begin failures++;
      $display("FAIL second_read got hit/way=%0b/%0d exp 1/0", r_hit, r_way); end
    checks++; if (cnt_access !== ex(2)) begin failures++; $display("FAIL rh_cnt_access got=%0d exp=%0d", cnt_access, ex(2)); end
    checks++; if (cnt_hits !== ex(1)) begin failures++; $display("FAIL rh_cnt_hits got=%0d exp=%0d", cnt_hits, ex(1)); end
    checks++; if (cnt_misses !== ex(1)) begin failures++; $display("FAIL rh_cnt_misses got=%0d exp=%0d", cnt_misses, ex(1)); end
    checks++; if (cnt_reads !== ex(2)) begin failures++; $display("FAIL rh_cnt_reads got=%0d exp=%0d", cnt_reads, ex(2)); end
  endtask

  task automatic test_lru();
    logic [31:0] fill [4] = '{32'h0, 32'h800, 32'h1000, 32'h1800};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_req(2'd0, fill[i]);
      checks++; if ({r_hit, r_way} !== {1'b0, 2'(i)}) begin failures++;
        $display("FAIL lru_fill%0d got hit/way=%0b/%0d exp 0/%0d", i, r_hit, r_way, i); end
    end
    do_req(2'd0, 32'h0);
    checks++; if ({r_hit, r_way} !== 3'b1_00) begin failures++; $display("FAIL lru_rehit got hit/way=%0b/%0d exp 1/0", r_hit, r_way); end
    do_req(2'd0, 32'h2000);
    checks++; if ({r_hit, r_way, r_evict, r_wb} !== 5'b0_01_1_0) begin failures++;
      $display("FAIL lru_victim got hit/way/ev/wb=%0b/%0d/%0b/%0b exp 0/1/1/0", r_hit, r_way, r_evict, r_wb); end
    // ages now 1,0,3,2 -> 0x800 refills into way 2
    do_req(2'd0, 32'h800);
    checks++; if ({r_hit, r_way, r_evict} !== 4'b0_10_1) begin failures++;
      $display("FAIL lru_second_victim got hit/way/ev=%0b/%0d/%0b exp 0/2/1", r_hit, r_way, r_evict); end
    checks++; if (cnt_evictions !== ex(2)) begin failures++; $display("FAIL lru_cnt_evict got=%0d exp=%0d", cnt_evictions, ex(2)); end
  endtask

  task automatic test_writeback();
    apply_reset();
    do_req(2'd1, 32'h0);
    checks++; if ({r_hit, r_way, r_evict} !== 4'b0) begin failures++;
      $display("FAIL wb_write_miss got hit/way/ev=%0b/%0d/%0b exp 0/0/0", r_hit, r_way, r_evict); end
    do_req(2'd0, 32'h800); do_req(2'd0, 32'h1000); do_req(2'd0, 32'h1800);
    do_req(2'd0, 32'h2000);
    checks++; if ({r_hit, r_way, r_evict, r_wb} !== 5'b0_00_1_1) begin failures++;
      $display("FAIL wb_victim got hit/way/ev/wb=%0b/%0d/%0b/%0b exp 0/0/1/1", r_hit, r_way, r_evict, r_wb); end
    checks++; if (cnt_writebacks !== ex(1)) begin failures++; $display("FAIL wb_cnt_wb got=%0d exp=%0d", cnt_writebacks, ex(1)); end
    checks++; if (cnt_evictions !== ex(1)) begin failures++; $display("FAIL wb_cnt_evict got=%0d exp=%0d", cnt_evictions, ex(1)); end
    checks++; if (cnt_writes !== ex(1)) begin failures++; $display("FAIL wb_cnt_writes got=%0d exp=%0d", cnt_writes, ex(1)); end
    checks++; if (cnt_misses !== ex(5)) begin failures++; $display("FAIL wb_cnt_misses got=%0d exp=%0d", cnt_misses, ex(5)); end
  endtask

  task automatic test_invalidate();
    apply_reset();
    do_req(2'd0, 32'h0); do_req(2'd0, 32'h800); do_req(2'd0, 32'h1000); do_req(2'd0, 32'h1800);
    do_req(2'd2, 32'h800);
    checks++; if ({r_hit, r_way, r_evict, r_wb} !== 5'b1_01_0_0) begin failures++;
      $display("FAIL inv_hit got hit/way/ev/wb=%0b/%0d/%0b/%0b exp 1/1/0/0", r_hit, r_way, r_evict, r_wb); end
    checks++; if (cnt_invalidates !== ex(1)) begin failures++; $display("FAIL inv_cnt got=%0d exp=%0d", cnt_invalidates, ex(1)); end
    checks++; if (cnt_access !== ex(4)) begin failures++; $display("FAIL inv_cnt_access got=%0d exp=%0d", cnt_access, ex(4)); end
    do_req(2'd2, 32'h2800);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL inv_miss got hit=%0b exp=0", r_hit); end
    do_req(2'd0, 32'h2000);
    checks++; if ({r_hit, r_way, r_evict} !== 4'b0_01_0) begin failures++;
      $display("FAIL inv_refill got hit/way/ev=%0b/%0d/%0b exp 0/1/0", r_hit, r_way, r_evict); end
    checks++; if (cnt_invalidates !== ex(2)) begin failures++; $display("FAIL inv_cnt2 got=%0d exp=%0d", cnt_invalidates, ex(2)); end
    do_req(2'd3, 32'h0);
    checks++; if ({r_hit, r_way, r_evict, r_wb} !== 5'b0) begin failures++;
      $display("FAIL noop_flags got=%0b exp=0", {r_hit, r_way, r_evict, r_wb}); end
    checks++; if (cnt_access !== ex(5)) begin failures++; $display("FAIL noop_cnt_access got=%0d exp=%0d", cnt_access, ex(5)); end
  endtask

  task automatic test_nru();
    apply_reset();
    do_req(2'd0, 32'h0); do_req(2'd0, 32'h800); do_req(2'd0, 32'h1000); do_req(2'd0, 32'h1800);
    do_req(2'd0, 32'h2000);
    checks++; if ({n_r_way, n_r_evict} !== 3'b00_1) begin failures++;
      $display("FAIL nru_victim got way/ev=%0d/%0b exp 0/1", n_r_way, n_r_evict); end
    // hits on ways 0,1,2 clear the NRU bits to only way 2; LRU ages end at 2,1,0,3
    apply_reset();
    do_req(2'd0, 32'h0); do_req(2'd0, 32'h800); do_req(2'd0, 32'h1000); do_req(2'd0, 32'h1800);
    do_req(2'd0, 32'h0); do_req(2'd0, 32'h800); do_req(2'd0, 32'h1000);
    do_req(2'd0, 32'h2000);
    checks++; if (n_r_way !== 2'd0) begin failures++; $display("FAIL nru_after_clear got way=%0d exp=0", n_r_way); end
    checks++; if (r_way !== 2'd3) begin failures++; $display("FAIL lru_vs_nru got way=%0d exp=3", r_way); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] rdy, rv;
    apply_reset();
    req_op = 2'd0; req_addr = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rdy[i] = req_ready; rv[i] = resp_valid;
    end
    req_valid = 1'b0;
    checks++; if (rdy !== 9'b100100100) begin failures++; $display("FAIL b2b_ready got=%b exp=100100100", rdy); end
    checks++; if (rv !== 9'b100100100) begin failures++; $display("FAIL b2b_resp got=%b exp=100100100", rv); end
    checks++; if (cnt_access !== ex(3)) begin failures++; $display("FAIL b2b_cnt_access got=%0d exp=%0d", cnt_access, ex(3)); end
  endtask

  task automatic test_rst_mid();
    int seen;
    apply_reset();
    do_req(2'd0, 32'h80);
    do_req(2'd0, 32'h80);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL rstmid_prehit got=%0b exp=1", r_hit); end
    req_op = 2'd0; req_addr = 32'h80; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_resp got=%0d pulses exp=0", seen); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", req_ready); end
    do_req(2'd0, 32'h80);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL rstmid_miss got hit=%0b exp=0", r_hit); end
    checks++; if (cnt_access !== ex(1)) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=%0d", cnt_access, ex(1)); end
  endtask

  task automatic test_stats_clear();
    logic [31:0] orv;
    apply_reset();
    do_req(2'd0, 32'h0);
    req_op = 2'd0; req_addr = 32'h800; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    orv = cnt_access | cnt_reads | cnt_writes | cnt_invalidates | cnt_hits | cnt_misses | cnt_evictions | cnt_writebacks;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL clr_resp got=%0b exp=1", resp_valid); end
    checks++; if (orv !== 32'd0) begin failures++; $display("FAIL clr_counters got=%0h exp=0", orv); end
    do_req(2'd0, 32'h800);
    checks++; if ({r_hit, r_way} !== 3'b1_01) begin failures++; $display("FAIL clr_array_kept got hit/way=%0b/%0d exp 1/1", r_hit, r_way); end
    checks++; if (cnt_hits !== ex(1)) begin failures++; $display("FAIL clr_cnt_hits got=%0d exp=%0d", cnt_hits, ex(1)); end
    checks++; if (cnt_misses !== ex(0)) begin failures++; $display("FAIL clr_cnt_misses got=%0d exp=%0d", cnt_misses, ex(0)); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read_hit();
    test_lru();
    test_writeback();
    test_invalidate();
    test_nru();
    test_back_to_back();
    test_rst_mid();
    test_stats_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
